// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [7:0] ACK     = 8'h5A;
  localparam logic [7:0] NAK     = 8'hEE;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] MAX_LEN = 8'd16;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CMD    = 4'd1;
  localparam logic [3:0] ST_ADDR   = 4'd2;
  localparam logic [3:0] ST_LEN    = 4'd3;
  localparam logic [3:0] ST_DATA   = 4'd4;
  localparam logic [3:0] ST_CSUM   = 4'd5;
  localparam logic [3:0] ST_TX     = 4'd6;
  localparam logic [3:0] ST_NEXT   = 4'd7;
  localparam logic [3:0] ST_RDWAIT = 4'd8;

  function automatic logic len_ok(input logic [7:0] len);
    return (len != 8'd0) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: reloadable down-counter, expire_o flags terminal count while enabled.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int              CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // A reload in the same cycle always beats expiry.
  assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: writes/reads a 16-entry external BRAM and answers over the UART TX handshake.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | hunting for header 0xA5, other bytes dropped
// ST_CMD    | expecting command byte
// ST_ADDR   | expecting address byte (upper nibble must be 0)
// ST_LEN    | expecting length byte (1..16)
// ST_DATA   | write payload, each byte written on arrival
// ST_CSUM   | expecting checksum byte
// ST_TX     | byte on tx_data, send_en high until tx_done
// ST_NEXT   | send_en low gap, choose next response byte
// ST_RDWAIT | waiting RD_LAT cycles for douta
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       wea,
  output logic [3:0] addra,
  output logic [7:0] dina,
  input  logic [7:0] douta,
  output logic [7:0] tx_data,
  output logic       send_en,
  input  logic       tx_done,
  output logic       err
);

  localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  logic [3:0]    state_q, state_d;
  logic          is_rd_q, is_rd_d;
  logic [3:0]    base_q, base_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic          last_q, last_d;
  logic [RW-1:0] rdw_q, rdw_d;
  logic          wea_q, wea_d;
  logic [3:0]    addra_q, addra_d;
  logic [7:0]    dina_q, dina_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          send_en_q, send_en_d;
  logic          err_q, err_d;

  logic nak;
  logic rx_state;
  logic to_load, to_en, to_expire;

  assign rx_state = (state_q <= ST_CSUM);
  assign to_load  = rx_done && rx_state;
  assign to_en    = rx_state && (state_q != ST_IDLE);

  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load_i    (to_load),
    .en_i      (to_en),
    .expire_o  (to_expire)
  );

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    last_d    = last_q;
    rdw_d     = rdw_q;
    wea_d     = 1'b0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    tx_data_d = tx_data_q;
    send_en_d = send_en_q;
    err_d     = 1'b0;
    nak       = 1'b0;

    if (to_expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_done && (rx_data == HDR)) begin
            csum_d  = 8'h00;
            idx_d   = 5'd0;
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (rx_done) begin
            csum_d  = csum_q ^ rx_data;
            is_rd_d = (rx_data == CMD_RD);
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD))
              state_d = ST_ADDR;
            else
              nak = 1'b1;
          end
        end
        ST_ADDR: begin
          if (rx_done) begin
            csum_d = csum_q ^ rx_data;
            base_d = rx_data[3:0];
            if (rx_data[7:4] != 4'h0)
              nak = 1'b1;
            else
              state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_done) begin
            csum_d = csum_q ^ rx_data;
            len_d  = rx_data[4:0];
            if (!len_ok(rx_data))
              nak = 1'b1;
            else
              state_d = is_rd_q ? ST_CSUM : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_done) begin
            csum_d  = csum_q ^ rx_data;
            wea_d   = 1'b1;
            dina_d  = rx_data;
            addra_d = base_q + idx_q[3:0];
            idx_d   = idx_q + 5'd1;
            if ((idx_q + 5'd1) == len_q)
              state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_done) begin
            if (rx_data != csum_q) begin
              nak = 1'b1;
            end else begin
              // Accumulator is reused as the XOR of bytes read back.
              csum_d    = 8'h00;
              idx_d     = 5'd0;
              tx_data_d = ACK;
              send_en_d = 1'b1;
              last_d    = 1'b0;
              state_d   = ST_TX;
            end
          end
        end
        ST_TX: begin
          if (tx_done) begin
            send_en_d = 1'b0;
            state_d   = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else if (!is_rd_q) begin
            tx_data_d = 8'h00;
            send_en_d = 1'b1;
            last_d    = 1'b1;
            state_d   = ST_TX;
          end else if (idx_q != len_q) begin
            addra_d = base_q + idx_q[3:0];
            rdw_d   = RW'(RD_LAT);
            state_d = ST_RDWAIT;
          end else begin
            tx_data_d = csum_q;
            send_en_d = 1'b1;
            last_d    = 1'b1;
            state_d   = ST_TX;
          end
        end
        ST_RDWAIT: begin
          if (rdw_q == '0) begin
            tx_data_d = douta;
            csum_d    = csum_q ^ douta;
            idx_d     = idx_q + 5'd1;
            send_en_d = 1'b1;
            state_d   = ST_TX;
          end else begin
            rdw_d = rdw_q - RW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (nak) begin
      err_d     = 1'b1;
      tx_data_d = NAK;
      send_en_d = 1'b1;
      last_d    = 1'b1;
      state_d   = ST_TX;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      is_rd_q   <= 1'b0;
      base_q    <= 4'h0;
      len_q     <= 5'd0;
      idx_q     <= 5'd0;
      csum_q    <= 8'h00;
      last_q    <= 1'b0;
      rdw_q     <= '0;
      wea_q     <= 1'b0;
      addra_q   <= 4'h0;
      dina_q    <= 8'h00;
      tx_data_q <= 8'h00;
      send_en_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      last_q    <= last_d;
      rdw_q     <= rdw_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      tx_data_q <= tx_data_d;
      send_en_q <= send_en_d;
      err_q     <= err_d;
    end
  end

  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign tx_data = tx_data_q;
  assign send_en = send_en_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a behavioural BRAM and UART transmitter.
module tb_uart_cmd_parser;

  localparam int TO  = 40;
  localparam int RDL = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       wea;
  logic [3:0] addra;
  logic [7:0] dina;
  logic [7:0] douta;
  logic [7:0] tx_data;
  logic       send_en;
  logic       tx_done;
  logic       tx_done_m, tx_done_s;
  logic       err;

  assign tx_done = tx_done_m | tx_done_s;

  uart_cmd_parser #(
    .RD_LAT      (RDL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .tx_data   (tx_data),
    .send_en   (send_en),
    .tx_done   (tx_done),
    .err       (err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // BRAM with RDL-cycle read latency
  logic [7:0] mem [16];
  logic [7:0] rd_pipe;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rd_pipe = 8'h00;
    douta   = 8'h00;
  end
  always @(posedge sys_clk) begin
    if (wea) mem[addra] <= dina;
    rd_pipe <= mem[addra];
    douta   <= rd_pipe;
  end

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [11:0] wr_q[$];
  logic [11:0] exp_wr[$];
  logic [7:0]  pay_q[$];

  initial begin
    tx_done_m = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (send_en) begin
        tx_q.push_back(tx_data);
        repeat (3) @(posedge sys_clk);
        #1 tx_done_m = 1'b1;
        @(posedge sys_clk); #1 tx_done_m = 1'b0;
      end
    end
  end

  int   err_cnt = 0;
  int   hs_bad = 0;
  int   first_lat = 0;
  int   lat_start = 0;
  logic lat_arm = 1'b0;
  logic prev_se = 1'b0, prev_txd = 1'b0;
  logic [7:0] prev_tx = 8'h00;
  always @(negedge sys_clk) begin
    if (err) err_cnt++;
    if (wea) wr_q.push_back({addra, dina});
    if (prev_txd && prev_se && send_en) hs_bad++;
    if (prev_se && send_en && (tx_data != prev_tx)) hs_bad++;
    if (rx_done) begin
      lat_arm   = 1'b1;
      lat_start = cyc;
    end
    if (send_en && !prev_se && lat_arm) begin
      first_lat = cyc - lat_start;
      lat_arm   = 1'b0;
    end
    prev_se  = send_en;
    prev_txd = tx_done;
    prev_tx  = tx_data;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic       last_wea;
  logic [3:0] last_addra;
  logic [7:0] last_dina;

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge sys_clk); #1;
    rx_done    = 1'b0;
    last_wea   = wea;
    last_addra = addra;
    last_dina  = dina;
    repeat (2) @(posedge sys_clk);
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] adr,
                          input logic [7:0] len, input logic bad_cs);
    logic [7:0] cs;
    logic [3:0] ea;
    cs = cmd ^ adr ^ len;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(adr);
    send_byte(len);
    for (int i = 0; i < pay_q.size(); i++) begin
      send_byte(pay_q[i]);
      cs = cs ^ pay_q[i];
      ea = adr[3:0] + 4'(i);
      check_val("wea_lat", 32'(last_wea), 32'(1));
      check_val("wea_addr", 32'(last_addra), 32'(ea));
      check_val("wea_data", 32'(last_dina), 32'(pay_q[i]));
    end
    if (bad_cs) cs = cs ^ 8'hFF;
    send_byte(cs);
    pay_q.delete();
  endtask

  task automatic check_rsp(input string tag);
    int n;
    n = 0;
    while ((tx_q.size() < exp_q.size()) && (n < 3000)) begin
      @(posedge sys_clk);
      n++;
    end
    repeat (12) @(posedge sys_clk);
    #2;
    check_val({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < tx_q.size()); i++)
      check_val($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
    check_val({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; (i < exp_wr.size()) && (i < wr_q.size()); i++)
      check_val($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_wr[i]));
    tx_q.delete();
    exp_q.delete();
    wr_q.delete();
    exp_wr.delete();
  endtask

  initial begin
    int e0, n, t0, el;
    sys_rst_n = 1'b0;
    rx_data   = 8'h00;
    rx_done   = 1'b0;
    tx_done_s = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check_val("rst_wea", 32'(wea), 32'(0));
    check_val("rst_addra", 32'(addra), 32'(0));
    check_val("rst_dina", 32'(dina), 32'(0));
    check_val("rst_tx_data", 32'(tx_data), 32'(0));
    check_val("rst_send_en", 32'(send_en), 32'(0));
    check_val("rst_err", 32'(err), 32'(0));
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // WRITE 3..5 = 11 22 33; a stray A5 during the ACK must be ignored
    e0 = err_cnt;
    pay_q = {8'h11, 8'h22, 8'h33};
    send_pkt(8'h01, 8'h03, 8'h03, 1'b0);
    send_byte(8'hA5);
    exp_q  = {8'h5A, 8'h00};
    exp_wr = {12'h311, 12'h422, 12'h533};
    check_rsp("wr1");
    check_val("wr1_err", 32'(err_cnt - e0), 32'(0));

    send_pkt(8'h02, 8'h03, 8'h02, 1'b0);
    exp_q = {8'h5A, 8'h11, 8'h22, 8'h33};
    check_rsp("rd1");
    check_val("rd1_lat_ok", 32'(first_lat <= RDL + 2), 32'(1));

    pay_q = {8'hAA, 8'hBB};
    send_pkt(8'h01, 8'h0F, 8'h02, 1'b0);
    exp_q  = {8'h5A, 8'h00};
    exp_wr = {12'hFAA, 12'h0BB};
    check_rsp("wrap_wr");

    send_pkt(8'h02, 8'h0F, 8'h02, 1'b0);
    exp_q = {8'h5A, 8'hAA, 8'hBB, 8'h11};
    check_rsp("wrap_rd");

    // junk in IDLE plus a tx_done with send_en low: both silently ignored
    e0 = err_cnt;
    send_byte(8'h33);
    @(posedge sys_clk); #1 tx_done_s = 1'b1;
    @(posedge sys_clk); #1 tx_done_s = 1'b0;
    check_rsp("idle_junk");
    check_val("idle_junk_err", 32'(err_cnt - e0), 32'(0));

    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03); send_byte(8'h00);
    exp_q = {8'hEE};
    check_rsp("len0");
    check_val("len0_err", 32'(err_cnt - e0), 32'(1));

    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
    exp_q = {8'hEE};
    check_rsp("len17");
    check_val("len17_err", 32'(err_cnt - e0), 32'(1));

    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h07);
    exp_q = {8'hEE};
    check_rsp("cmd07");
    check_val("cmd07_err", 32'(err_cnt - e0), 32'(1));

    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h13);
    exp_q = {8'hEE};
    check_rsp("badaddr");
    check_val("badaddr_err", 32'(err_cnt - e0), 32'(1));

    e0 = err_cnt;
    pay_q = {8'h5C};
    send_pkt(8'h01, 8'h08, 8'h01, 1'b1);
    exp_q  = {8'hEE};
    exp_wr = {12'h85C};
    check_rsp("badcs");
    check_val("badcs_err", 32'(err_cnt - e0), 32'(1));

    send_pkt(8'h02, 8'h00, 8'h10, 1'b0);
    exp_q = {8'h5A, 8'hBB, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00,
             8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h4D};
    check_rsp("rd16");

    // partial packet then silence
    e0 = err_cnt;
    send_byte(8'hA5);
    @(posedge sys_clk); #1;
    rx_data = 8'h01;
    rx_done = 1'b1;
    t0 = cyc;
    @(posedge sys_clk); #1 rx_done = 1'b0;
    n = 0;
    while (!err && (n < TO + 20)) begin
      @(posedge sys_clk); #1;
      n++;
    end
    el = cyc - t0;
    check_val("to_window", 32'((el >= TO) && (el <= TO + 2)), 32'(1));
    check_rsp("to");
    check_val("to_err", 32'(err_cnt - e0), 32'(1));
    send_pkt(8'h02, 8'h08, 8'h01, 1'b0);
    exp_q = {8'h5A, 8'h5C, 8'h5C};
    check_rsp("after_to");

    // reset while the second READ response byte is on the wire
    send_pkt(8'h02, 8'h03, 8'h03, 1'b0);
    n = 0;
    while ((tx_q.size() < 2) && (n < 500)) begin
      @(posedge sys_clk); #2;
      n++;
    end
    check_val("pre_rst_send_en", 32'(send_en), 32'(1));
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check_val("mid_rst_send_en", 32'(send_en), 32'(0));
    check_val("mid_rst_wea", 32'(wea), 32'(0));
    check_val("mid_rst_addra", 32'(addra), 32'(0));
    check_val("mid_rst_dina", 32'(dina), 32'(0));
    check_val("mid_rst_tx_data", 32'(tx_data), 32'(0));
    check_val("mid_rst_err", 32'(err), 32'(0));
    repeat (3) @(posedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q = {8'h5A, 8'h11};
    check_rsp("rst_abort");

    pay_q = {8'h77};
    send_pkt(8'h01, 8'h01, 8'h01, 1'b0);
    exp_q  = {8'h5A, 8'h00};
    exp_wr = {12'h177};
    check_rsp("after_rst");

    check_val("handshake", 32'(hs_bad), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
